// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared state, direction and edge-mode encodings for the
//               sprite mover and its raster scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAW  = 3'd1,
      WAIT  = 3'd2,
      ERASE = 3'd3,
      MOVE  = 3'd4
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam logic [1:0] MODE_CLAMP  = 2'b00;
   localparam logic [1:0] MODE_WRAP   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   // Opposite directions differ only in bit 0 (up<->down, left<->right).
   function automatic logic [1:0] reverse_dir(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_mover_rect_scan.sv
`default_nettype none
// ============================================================================
// Module      : rect_scan
// Description : Raster scanner over a RECT_W x RECT_H rectangle; qx runs
//               fastest, and the scanner returns to (0,0) after the last pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_scan #(
   parameter int RECT_W = 41,
   parameter int RECT_H = 11,
   parameter int QX_W   = (RECT_W > 1) ? $clog2(RECT_W) : 1,
   parameter int QY_W   = (RECT_H > 1) ? $clog2(RECT_H) : 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            enable,
   output logic [QX_W-1:0] qx,
   output logic [QY_W-1:0] qy,
   output logic            last
);

   localparam logic [QX_W-1:0] QX_MAX = QX_W'(RECT_W - 1);
   localparam logic [QY_W-1:0] QY_MAX = QY_W'(RECT_H - 1);

   logic [QX_W-1:0] qx_q, qx_d;
   logic [QY_W-1:0] qy_q, qy_d;

   assign qx   = qx_q;
   assign qy   = qy_q;
   assign last = (qx_q == QX_MAX) && (qy_q == QY_MAX);

   // Advance one pixel per enabled cycle, wrapping rows and clearing at the end.
   always_comb begin
      qx_d = qx_q;
      qy_d = qy_q;
      if (enable) begin
         if (last) begin
            qx_d = '0;
            qy_d = '0;
         end else if (qx_q == QX_MAX) begin
            qx_d = '0;
            qy_d = qy_q + QY_W'(1);
         end else begin
            qx_d = qx_q + QX_W'(1);
         end
      end
   end

   // Scanner position register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         qx_q <= '0;
         qy_q <= '0;
      end else begin
         qx_q <= qx_d;
         qy_q <= qy_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mover
// Description : Draws a solid rectangle into the VGA adapter one pixel per
//               clock, then periodically erases it, steps it one pixel and
//               redraws it, with clamp / wrap / bounce edge handling.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_mover #(
   parameter int         X_W             = 8,
   parameter int         Y_W             = 7,
   parameter int         SCR_W           = 160,
   parameter int         SCR_H           = 120,
   parameter int         RECT_W          = 41,
   parameter int         RECT_H          = 11,
   parameter int         TICKS_PER_FRAME = 833334,
   parameter int         FRAMES_PER_STEP = 15,
   parameter logic [2:0] BG_COLOUR       = 3'b111
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           go,
   input  logic           stop,
   input  logic [X_W-1:0] in_x,
   input  logic [Y_W-1:0] in_y,
   input  logic [2:0]     colour,
   input  logic [1:0]     dir,
   input  logic [1:0]     mode,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic [2:0]     out_colour,
   output logic           plot,
   output logic           busy,
   output logic           edge_hit
);

   import sprite_pkg::*;

   localparam int QX_W   = (RECT_W > 1) ? $clog2(RECT_W) : 1;
   localparam int QY_W   = (RECT_H > 1) ? $clog2(RECT_H) : 1;
   localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int FC_W   = $clog2(FRAMES_PER_STEP + 1);

   localparam logic [X_W-1:0]    MAX_X      = X_W'(SCR_W - RECT_W);
   localparam logic [Y_W-1:0]    MAX_Y      = Y_W'(SCR_H - RECT_H);
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
   localparam logic [FC_W-1:0]   FRAME_LAST = FC_W'(FRAMES_PER_STEP - 1);

   state_t          state_q, state_d;
   logic [X_W-1:0]  pos_x_q, pos_x_d;
   logic [Y_W-1:0]  pos_y_q, pos_y_d;
   logic [2:0]      colour_q, colour_d;
   logic [1:0]      dir_q, dir_d;
   logic [1:0]      mode_q, mode_d;
   logic            stop_pend_q, stop_pend_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [TICK_W-1:0] tick_cnt_q;
   logic            frame_tick;

   logic [QX_W-1:0] qx;
   logic [QY_W-1:0] qy;
   logic            scan_last;
   logic            scan_en;

   // Candidates carry one extra bit so stepping below 0 shows up as a large value.
   logic [X_W:0]    step_x;
   logic [Y_W:0]    step_y;
   logic [X_W-1:0]  bounce_x;
   logic [Y_W-1:0]  bounce_y;
   logic            step_ok;

   rect_scan #(
      .RECT_W (RECT_W),
      .RECT_H (RECT_H),
      .QX_W   (QX_W),
      .QY_W   (QY_W)
   ) u_scan (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (scan_en),
      .qx      (qx),
      .qy      (qy),
      .last    (scan_last)
   );

   assign frame_tick = (tick_cnt_q == TICK_LAST);
   assign out_x      = pos_x_q + X_W'(qx);
   assign out_y      = pos_y_q + Y_W'(qy);

   // Free-running frame timebase, independent of the sprite state.
   always_ff @(posedge clock) begin
      if (!reset_n)        tick_cnt_q <= '0;
      else if (frame_tick) tick_cnt_q <= '0;
      else                 tick_cnt_q <= tick_cnt_q + TICK_W'(1);
   end

   // One-pixel step in the current direction, plus the step in the reversed direction.
   always_comb begin
      step_x   = {1'b0, pos_x_q};
      step_y   = {1'b0, pos_y_q};
      bounce_x = pos_x_q;
      bounce_y = pos_y_q;
      case (dir_q)
         DIR_UP: begin
            step_y   = {1'b0, pos_y_q} - (Y_W+1)'(1);
            bounce_y = pos_y_q + Y_W'(1);
         end
         DIR_DOWN: begin
            step_y   = {1'b0, pos_y_q} + (Y_W+1)'(1);
            bounce_y = pos_y_q - Y_W'(1);
         end
         DIR_LEFT: begin
            step_x   = {1'b0, pos_x_q} - (X_W+1)'(1);
            bounce_x = pos_x_q + X_W'(1);
         end
         DIR_RIGHT: begin
            step_x   = {1'b0, pos_x_q} + (X_W+1)'(1);
            bounce_x = pos_x_q - X_W'(1);
         end
      endcase
      step_ok = (step_x <= {1'b0, MAX_X}) && (step_y <= {1'b0, MAX_Y});
   end

   // Sequencer next-state, datapath updates and VGA-side outputs.
   always_comb begin
      state_d     = state_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      colour_d    = colour_q;
      dir_d       = dir_q;
      mode_d      = mode_q;
      stop_pend_d = stop_pend_q;
      frame_cnt_d = frame_cnt_q;
      scan_en     = 1'b0;
      plot        = 1'b0;
      busy        = 1'b1;
      edge_hit    = 1'b0;
      out_colour  = BG_COLOUR;

      if (state_q != IDLE && stop) stop_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (go) begin
               pos_x_d     = (in_x > MAX_X) ? MAX_X : in_x;
               pos_y_d     = (in_y > MAX_Y) ? MAX_Y : in_y;
               colour_d    = colour;
               dir_d       = dir;
               mode_d      = mode;
               stop_pend_d = 1'b0;
               state_d     = DRAW;
            end
         end
         DRAW: begin
            plot       = 1'b1;
            scan_en    = 1'b1;
            out_colour = colour_q;
            if (scan_last) begin
               frame_cnt_d = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (frame_tick) frame_cnt_d = frame_cnt_q + FC_W'(1);
            if (stop_pend_q || stop || (frame_tick && frame_cnt_q == FRAME_LAST))
               state_d = ERASE;
         end
         ERASE: begin
            plot    = 1'b1;
            scan_en = 1'b1;
            if (scan_last) state_d = (stop_pend_q || stop) ? IDLE : MOVE;
         end
         MOVE: begin
            if (step_ok) begin
               pos_x_d = step_x[X_W-1:0];
               pos_y_d = step_y[Y_W-1:0];
               state_d = DRAW;
            end else begin
               edge_hit = 1'b1;
               case (mode_q)
                  MODE_WRAP: begin
                     case (dir_q)
                        DIR_UP:    pos_y_d = MAX_Y;
                        DIR_DOWN:  pos_y_d = '0;
                        DIR_LEFT:  pos_x_d = MAX_X;
                        DIR_RIGHT: pos_x_d = '0;
                     endcase
                     state_d = DRAW;
                  end
                  MODE_BOUNCE: begin
                     dir_d   = reverse_dir(dir_q);
                     pos_x_d = bounce_x;
                     pos_y_d = bounce_y;
                     state_d = DRAW;
                  end
                  MODE_CLAMP: state_d = IDLE;
                  default:    state_d = IDLE;  // reserved code behaves as clamp
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer and sprite register bank.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         colour_q    <= '0;
         dir_q       <= '0;
         mode_q      <= '0;
         stop_pend_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         colour_q    <= colour_d;
         dir_q       <= dir_d;
         mode_q      <= mode_d;
         stop_pend_q <= stop_pend_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mover
// Description : Directed self-checking bench for sprite_mover on a 16x12
//               screen with a 4x3 sprite, 4-clock frames and 2 frames/step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mover;

   import sprite_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       go;
   logic       stop;
   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] colour;
   logic [1:0] dir;
   logic [1:0] mode;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   logic       plot;
   logic       busy;
   logic       edge_hit;

   int n_tests = 0;
   int n_fail  = 0;

   sprite_mover #(
      .X_W             (8),
      .Y_W             (7),
      .SCR_W           (16),
      .SCR_H           (12),
      .RECT_W          (4),
      .RECT_H          (3),
      .TICKS_PER_FRAME (4),
      .FRAMES_PER_STEP (2),
      .BG_COLOUR       (3'b111)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .go         (go),
      .stop       (stop),
      .in_x       (in_x),
      .in_y       (in_y),
      .colour     (colour),
      .dir        (dir),
      .mode       (mode),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_colour (out_colour),
      .plot       (plot),
      .busy       (busy),
      .edge_hit   (edge_hit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   // Presents go (optionally with stop) for exactly one sampling edge.
   task automatic launch(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input logic [1:0] d, input logic [1:0] m, input logic with_stop);
      @(negedge clock);
      in_x = x; in_y = y; colour = c; dir = d; mode = m;
      go = 1'b1; stop = with_stop;
      @(posedge clock);
      #1 go = 1'b0; stop = 1'b0;
   endtask

   // Bounded wait at negedges until plot (sel=0) or busy (sel=1) reaches val.
   task automatic wait_for(input bit sel, input logic val, input string what);
      int n;
      n = 0;
      while (((sel ? busy : plot) !== val) && n < 100) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if ((sel ? busy : plot) !== val) begin
         n_fail++;
         $display("FAIL %s: %s = %b after 100 cycles, want %b", what,
                  sel ? "busy" : "plot", sel ? busy : plot, val);
      end
   endtask

   task automatic stop_and_drain(input string what);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      wait_for(1'b1, 1'b0, what);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b0 || busy !== 1'b0 || edge_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: plot=%b busy=%b edge=%b, want 0 0 0", plot, busy, edge_hit);
      end
      n_tests++;
      if (out_x !== 8'd0 || out_y !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_xy: x=%0d y=%0d, want 0 0", out_x, out_y);
      end
      n_tests++;
      if (out_colour !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_colour: got %b, want 111", out_colour);
      end
   endtask

   task automatic test_basic_up();
      logic [7:0] ex;
      logic [6:0] ey;
      int wlen;
      launch(8'd5, 7'd6, 3'b010, DIR_UP, MODE_CLAMP, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         ex = 8'd5 + 8'(i % 4);
         ey = 7'd6 + 7'(i / 4);
         n_tests++;
         if (plot !== 1'b1 || busy !== 1'b1 || out_x !== ex || out_y !== ey || out_colour !== 3'b010) begin
            n_fail++;
            $display("FAIL draw_px%0d: plot=%b busy=%b x=%0d y=%0d c=%b, want 1 1 x=%0d y=%0d c=010",
                     i, plot, busy, out_x, out_y, out_colour, ex, ey);
         end
      end
      // WAIT spans 5..8 cycles depending on frame phase; go inside it must be ignored.
      @(negedge clock);
      wlen = 0;
      while (plot === 1'b0 && wlen < 20) begin
         wlen++;
         go   = (wlen == 1);
         in_x = 8'd0;
         in_y = 7'd0;
         @(negedge clock);
      end
      go = 1'b0;
      n_tests++;
      if (wlen < 5 || wlen > 8) begin
         n_fail++;
         $display("FAIL wait_len: got %0d cycles, want 5..8", wlen);
      end
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clock);
         ex = 8'd5 + 8'(i % 4);
         ey = 7'd6 + 7'(i / 4);
         n_tests++;
         if (plot !== 1'b1 || out_x !== ex || out_y !== ey || out_colour !== 3'b111) begin
            n_fail++;
            $display("FAIL erase_px%0d: plot=%b x=%0d y=%0d c=%b, want 1 x=%0d y=%0d c=111",
                     i, plot, out_x, out_y, out_colour, ex, ey);
         end
      end
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b0 || busy !== 1'b1 || edge_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL move_cycle: plot=%b busy=%b edge=%b, want 0 1 0", plot, busy, edge_hit);
      end
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_x !== 8'd5 || out_y !== 7'd5 || out_colour !== 3'b010) begin
         n_fail++;
         $display("FAIL redraw_up: plot=%b x=%0d y=%0d c=%b, want 1 5 5 010", plot, out_x, out_y, out_colour);
      end
      stop_and_drain("basic_drain");
   endtask

   task automatic test_clamp();
      launch(8'd3, 7'd0, 3'b001, DIR_UP, MODE_CLAMP, 1'b0);
      @(negedge clock);
      wait_for(1'b0, 1'b0, "clamp_to_wait");
      wait_for(1'b0, 1'b1, "clamp_to_erase");
      wait_for(1'b0, 1'b0, "clamp_to_move");
      n_tests++;
      if (edge_hit !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clamp_edge: edge=%b busy=%b, want 1 1", edge_hit, busy);
      end
      @(negedge clock);
      n_tests++;
      if (busy !== 1'b0 || plot !== 1'b0 || edge_hit !== 1'b0 || out_x !== 8'd3 || out_y !== 7'd0) begin
         n_fail++;
         $display("FAIL clamp_idle: busy=%b plot=%b edge=%b x=%0d y=%0d, want 0 0 0 3 0",
                  busy, plot, edge_hit, out_x, out_y);
      end
   endtask

   task automatic test_wrap();
      launch(8'd2, 7'd0, 3'b100, DIR_UP, MODE_WRAP, 1'b0);
      @(negedge clock);
      wait_for(1'b0, 1'b0, "wrap_to_wait");
      wait_for(1'b0, 1'b1, "wrap_to_erase");
      wait_for(1'b0, 1'b0, "wrap_to_move");
      n_tests++;
      if (edge_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_edge: edge=%b, want 1", edge_hit);
      end
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || edge_hit !== 1'b0 || out_x !== 8'd2 || out_y !== 7'd9 || out_colour !== 3'b100) begin
         n_fail++;
         $display("FAIL wrap_redraw: plot=%b edge=%b x=%0d y=%0d c=%b, want 1 0 2 9 100",
                  plot, edge_hit, out_x, out_y, out_colour);
      end
      stop_and_drain("wrap_drain");
   endtask

   task automatic test_bounce();
      launch(8'd12, 7'd4, 3'b011, DIR_RIGHT, MODE_BOUNCE, 1'b0);
      @(negedge clock);
      wait_for(1'b0, 1'b0, "bounce_to_wait");
      wait_for(1'b0, 1'b1, "bounce_to_erase");
      wait_for(1'b0, 1'b0, "bounce_to_move");
      n_tests++;
      if (edge_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_edge: edge=%b, want 1", edge_hit);
      end
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_x !== 8'd11 || out_y !== 7'd4) begin
         n_fail++;
         $display("FAIL bounce_redraw: plot=%b x=%0d y=%0d, want 1 11 4", plot, out_x, out_y);
      end
      wait_for(1'b0, 1'b0, "bounce2_to_wait");
      wait_for(1'b0, 1'b1, "bounce2_to_erase");
      wait_for(1'b0, 1'b0, "bounce2_to_move");
      n_tests++;
      if (edge_hit !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_move2: edge=%b busy=%b, want 0 1", edge_hit, busy);
      end
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_x !== 8'd10 || out_y !== 7'd4) begin
         n_fail++;
         $display("FAIL bounce_left: plot=%b x=%0d y=%0d, want 1 10 4", plot, out_x, out_y);
      end
      stop_and_drain("bounce_drain");
   endtask

   task automatic test_stop_wait();
      int nplot;
      launch(8'd1, 7'd1, 3'b110, DIR_DOWN, MODE_CLAMP, 1'b0);
      @(negedge clock);
      wait_for(1'b0, 1'b0, "stop_to_wait");
      stop = 1'b1;
      @(posedge clock);
      #1 stop = 1'b0;
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_colour !== 3'b111 || out_x !== 8'd1 || out_y !== 7'd1) begin
         n_fail++;
         $display("FAIL stop_erase_start: plot=%b c=%b x=%0d y=%0d, want 1 111 1 1",
                  plot, out_colour, out_x, out_y);
      end
      nplot = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         if (plot === 1'b1 && out_colour === 3'b111) nplot++;
      end
      n_tests++;
      if (nplot != 11) begin
         n_fail++;
         $display("FAIL stop_erase_len: got %0d further erase cycles, want 11", nplot);
      end
      @(negedge clock);
      n_tests++;
      if (busy !== 1'b0 || plot !== 1'b0 || edge_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle: busy=%b plot=%b edge=%b, want 0 0 0", busy, plot, edge_hit);
      end
   endtask

   task automatic test_stop_with_go();
      int wlen;
      launch(8'd6, 7'd2, 3'b101, DIR_LEFT, MODE_CLAMP, 1'b1);
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_x !== 8'd6 || out_y !== 7'd2 || out_colour !== 3'b101) begin
         n_fail++;
         $display("FAIL stopgo_draw: plot=%b x=%0d y=%0d c=%b, want 1 6 2 101", plot, out_x, out_y, out_colour);
      end
      wait_for(1'b0, 1'b0, "stopgo_to_wait");
      wlen = 0;
      while (plot === 1'b0 && wlen < 20) begin
         wlen++;
         @(negedge clock);
      end
      n_tests++;
      if (wlen < 5 || wlen > 8) begin
         n_fail++;
         $display("FAIL stopgo_wait_len: got %0d cycles, want 5..8", wlen);
      end
      stop_and_drain("stopgo_drain");
   endtask

   task automatic test_reset_mid_draw();
      launch(8'd5, 7'd2, 3'b010, DIR_DOWN, MODE_CLAMP, 1'b0);
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b0 || busy !== 1'b0 || out_x !== 8'd0 || out_y !== 7'd0) begin
         n_fail++;
         $display("FAIL midreset: plot=%b busy=%b x=%0d y=%0d, want 0 0 0 0", plot, busy, out_x, out_y);
      end
      reset_n = 1'b1;
      launch(8'd200, 7'd100, 3'b011, DIR_UP, MODE_CLAMP, 1'b0);
      @(negedge clock);
      n_tests++;
      if (plot !== 1'b1 || out_x !== 8'd12 || out_y !== 7'd9) begin
         n_fail++;
         $display("FAIL start_clamped: plot=%b x=%0d y=%0d, want 1 12 9", plot, out_x, out_y);
      end
      repeat (3) @(negedge clock);
      n_tests++;
      if (out_x !== 8'd15 || out_y !== 7'd9) begin
         n_fail++;
         $display("FAIL right_edge_px: x=%0d y=%0d, want 15 9", out_x, out_y);
      end
      do_reset();
   endtask

   initial begin
      reset_n = 1'b0;
      go      = 1'b0;
      stop    = 1'b0;
      in_x    = '0;
      in_y    = '0;
      colour  = '0;
      dir     = '0;
      mode    = '0;
      test_reset();
      test_basic_up();
      test_clamp();
      test_wrap();
      test_bounce();
      test_stop_wait();
      test_stop_with_go();
      test_reset_mid_draw();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised successor to the single-direction rectangle animator on the VGA path.
- Draws a RECT_W x RECT_H solid rectangle one pixel per clock into the VGA adapter interface (x, y, colour, plot).
- Every FRAMES_PER_STEP frames it erases the rectangle, moves it one pixel in a selectable direction, and redraws it.
- Screen edges are handled per a selectable mode: clamp/stop, wrap, or bounce. A stop request is supported.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- RECT_W, 41, rectangle width in pixels
- RECT_H, 11, rectangle height in pixels
- TICKS_PER_FRAME, 833334, clocks per frame tick (use 101 in simulation)
- FRAMES_PER_STEP, 15, frame ticks between moves
- BG_COLOUR, 3'b111, erase colour

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- go  in  1  start request, sampled in IDLE only
- stop  in  1  stop request, level; sets a sticky pending flag
- in_x  in  X_W  start x of top-left corner, latched on go
- in_y  in  Y_W  start y of top-left corner, latched on go
- colour  in  3  draw colour, latched on go
- dir  in  2  initial direction, latched on go: 00 up, 01 down, 10 left, 11 right
- mode  in  2  edge mode, latched on go: 00 clamp, 01 wrap, 10 bounce, 11 treated as clamp
- out_x  out  X_W  pixel x = pos_x + qx
- out_y  out  Y_W  pixel y = pos_y + qy
- out_colour  out  3  latched colour in DRAW, BG_COLOUR otherwise
- plot  out  1  high only in DRAW and ERASE
- busy  out  1  high in every state except IDLE
- edge_hit  out  1  one-cycle pulse in MOVE when the requested move would leave the screen

Behaviour:
- Reset, on the clock edge with reset_n=0:
  - state IDLE; pos_x, pos_y, qx, qy, frame counter, tick counter and stop-pending all 0.
  - Resulting outputs: out_x=0, out_y=0, out_colour=BG_COLOUR, plot=0, busy=0, edge_hit=0.
  - Reset mid-operation abandons any draw or erase; no completion is attempted.
- Tick counter:
  - Free-running from reset; frame_tick is a 1-cycle pulse every TICKS_PER_FRAME clocks.
  - The frame counter counts frame_tick only in WAIT and is cleared on WAIT entry.
- IDLE:
  - go=1 latches in_x, in_y, colour, dir, mode; clears stop-pending; next state DRAW.
  - Latched positions are clamped to pos_x <= SCR_W-RECT_W and pos_y <= SCR_H-RECT_H.
  - go outside IDLE is ignored.
- DRAW:
  - plot=1 for exactly RECT_W*RECT_H consecutive cycles, starting the cycle after go is sampled.
  - Raster order: qx increments fastest, 0..RECT_W-1; qy runs 0..RECT_H-1.
  - On the last pixel (qx=RECT_W-1, qy=RECT_H-1) the scanner clears and the next state is WAIT.
- WAIT:
  - plot=0.
  - Exit to ERASE on the FRAMES_PER_STEP-th frame_tick after entry, or immediately (next cycle) if stop-pending=1.
- ERASE:
  - Same scan as DRAW, with out_colour=BG_COLOUR.
  - After the last pixel: next state IDLE if stop-pending=1, else MOVE.
- MOVE, one cycle, plot=0. Compute the candidate position with one extra bit of width to detect underflow/overflow; valid range is x in [0, SCR_W-RECT_W], y in [0, SCR_H-RECT_H]. If the candidate is in range: commit it, next state DRAW. Otherwise edge_hit=1 and:
  - Clamp: position unchanged, next state IDLE.
  - Wrap: position goes to the opposite limit (up from y=0 gives y=SCR_H-RECT_H; right from max x gives x=0), next state DRAW.
  - Bounce: dir reverses, one step is taken in the new direction, next state DRAW.
- stop:
  - A stop asserted in any non-IDLE state sets stop-pending.
  - stop in the same cycle as go in IDLE: go wins and pending is cleared.
- out_x and out_y are combinational from the registered pos + q. No out-of-screen pixel is ever plotted.

Decomposition:
- Package sprite_pkg holds:
  - state enum: IDLE, DRAW, WAIT, ERASE, MOVE
  - direction codes: DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
  - mode codes: MODE_CLAMP, MODE_WRAP, MODE_BOUNCE
- One sub-module, rect_scan, parametrised by RECT_W/RECT_H:
  - inputs: clock, reset_n, enable
  - outputs: qx, qy, last
  - reused by DRAW and ERASE.

Test Plan (RECT_W=4, RECT_H=3, SCR_W=16, SCR_H=12, TICKS_PER_FRAME=4, FRAMES_PER_STEP=2, BG_COLOUR=3'b111):
- go with in_x=5, in_y=6, colour=010, dir=up, mode=00 -> 12 plot cycles colour 010, pixels (5,6),(6,6)..(8,8); WAIT until the 2nd frame_tick; 12 erase cycles colour 111; redraw starts at (5,5).
- in_y=0, dir=up, mode=00 -> after the first erase, edge_hit high 1 cycle, no redraw, busy falls to 0, pos stays (x,0).
- in_y=0, dir=up, mode=01 -> edge_hit pulse, redraw at y=9.
- in_x=12, dir=right, mode=10 -> edge_hit pulse, redraw at x=11, subsequent moves leftward (x=10 next).
- stop pulsed during WAIT -> ERASE begins next cycle, 12 cycles colour 111, then IDLE, busy=0, no MOVE.
- reset_n=0 mid-DRAW -> next cycle plot=0, busy=0, out_x=0; then go with in_x=200 -> drawing starts at x=12.
